// File: rtl/reset_sequencer.sv
// Multi-channel reset sequencer: a global request asserts every channel, holds them, then
// releases them one by one in index order. Per-channel soft requests override individual outputs.
module reset_sequencer #(
  parameter int NUM_CH  = 4,
  parameter int HOLD    = 4,
  parameter int STAGGER = 2,
  parameter bit INIT    = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ASSERT,
  input  logic [NUM_CH-1:0] ASSERT_CH,
  output logic [NUM_CH-1:0] OUT_RST,
  output logic              ASSERT_OUT,
  output logic              BUSY,
  output logic              DONE
);

  if (NUM_CH < 1 || HOLD < 1 || STAGGER < 1) begin : g_bad_param
    $error("reset_sequencer: NUM_CH, HOLD and STAGGER must all be >= 1");
  end

  localparam int CNT_MAX = (HOLD > STAGGER) ? HOLD : STAGGER;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int IDX_W   = $clog2(NUM_CH) + 1;

  localparam logic [CNT_W-1:0] HOLD_LOAD    = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] STAGGER_LOAD = CNT_W'(STAGGER - 1);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_CH - 1);
  localparam logic [NUM_CH-1:0] SEQ_INIT    = {NUM_CH{INIT}};
  localparam bit SINGLE_CH                  = (NUM_CH == 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_RELEASE
  } state_t;

  localparam state_t STATE_INIT = INIT ? ST_IDLE : ST_HOLD;
  localparam logic [CNT_W-1:0] CNT_INIT = INIT ? '0 : HOLD_LOAD;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [IDX_W-1:0]  idx_q,   idx_d;
  logic [NUM_CH-1:0] seq_q,   seq_d;
  logic [NUM_CH-1:0] out_q,   out_d;
  logic              done_q,  done_d;

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    seq_d   = seq_q;
    done_d  = 1'b0;

    if (ASSERT) begin
      // Retrigger from any state; seq is cleared in the same edge so no channel blips high.
      state_d = ST_HOLD;
      cnt_d   = HOLD_LOAD;
      idx_d   = '0;
      seq_d   = '0;
    end else begin
      unique case (state_q)
        ST_HOLD: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            seq_d[0] = 1'b1;
            if (SINGLE_CH) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RELEASE;
              idx_d   = IDX_W'(1);
              cnt_d   = STAGGER_LOAD;
            end
          end
        end

        ST_RELEASE: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            for (int i = 0; i < NUM_CH; i++) begin
              if (IDX_W'(i) == idx_q) seq_d[i] = 1'b1;
            end
            if (idx_q == LAST_IDX) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
              cnt_d = STAGGER_LOAD;
            end
          end
        end

        ST_IDLE: ;

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output flop is fed from next-state values so OUT_RST comes straight off a register.
  assign out_d = seq_d & ~ASSERT_CH;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= STATE_INIT;
      cnt_q   <= CNT_INIT;
      idx_q   <= '0;
      seq_q   <= SEQ_INIT;
      out_q   <= SEQ_INIT;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      seq_q   <= seq_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign OUT_RST    = out_q;
  assign ASSERT_OUT = ~&out_q;
  assign BUSY       = (state_q != ST_IDLE);
  assign DONE       = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: three instances cover the default, INIT=0 and
// single-channel configurations; vector tables drive one edge per row repetition.
module tb_reset_sequencer;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: defaults (NUM_CH=4, HOLD=4, STAGGER=2, INIT=1)
  logic       rst_a, as_a, aout_a, busy_a, done_a;
  logic [3:0] ach_a, out_a;
  reset_sequencer dut_a (
    .CLK(clk), .RST(rst_a), .ASSERT(as_a), .ASSERT_CH(ach_a),
    .OUT_RST(out_a), .ASSERT_OUT(aout_a), .BUSY(busy_a), .DONE(done_a)
  );

  // DUT B: INIT=0, HOLD=3, STAGGER=1
  logic       rst_b, as_b, aout_b, busy_b, done_b;
  logic [3:0] ach_b, out_b;
  reset_sequencer #(.NUM_CH(4), .HOLD(3), .STAGGER(1), .INIT(1'b0)) dut_b (
    .CLK(clk), .RST(rst_b), .ASSERT(as_b), .ASSERT_CH(ach_b),
    .OUT_RST(out_b), .ASSERT_OUT(aout_b), .BUSY(busy_b), .DONE(done_b)
  );

  // DUT C: NUM_CH=1, HOLD=1
  logic rst_c, as_c, ach_c, out_c, aout_c, busy_c, done_c;
  reset_sequencer #(.NUM_CH(1), .HOLD(1), .STAGGER(2), .INIT(1'b1)) dut_c (
    .CLK(clk), .RST(rst_c), .ASSERT(as_c), .ASSERT_CH(ach_c),
    .OUT_RST(out_c), .ASSERT_OUT(aout_c), .BUSY(busy_c), .DONE(done_c)
  );

  int total = 0;
  int bad   = 0;
  int cur   = 0;

  // Selected DUT's outputs; DUT C is padded with released (1) upper bits.
  logic [3:0] o_out;
  logic       o_aout, o_busy, o_done;
  always_comb begin
    o_out = 4'hF; o_aout = 1'b0; o_busy = 1'b0; o_done = 1'b0;
    case (cur)
      0: begin o_out = out_a; o_aout = aout_a; o_busy = busy_a; o_done = done_a; end
      1: begin o_out = out_b; o_aout = aout_b; o_busy = busy_b; o_done = done_b; end
      default: begin o_out = {3'b111, out_c}; o_aout = aout_c; o_busy = busy_c; o_done = done_c; end
    endcase
  end

  typedef struct {
    int         n;
    logic       a;
    logic [3:0] ach;
    logic [3:0] exp_out;
    logic       exp_busy;
    logic       exp_done;
  } vec_t;

  vec_t vq[$];

  function automatic void add(int n, logic a, logic [3:0] ach, logic [3:0] eo, logic eb, logic ed);
    vq.push_back('{n, a, ach, eo, eb, ed});
  endfunction

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_all(string tag, logic [3:0] eo, logic eb, logic ed);
    check({tag, " out"},  {4'h0, o_out},  {4'h0, eo});
    check({tag, " aout"}, {7'h0, o_aout}, {7'h0, (eo != 4'hF)});
    check({tag, " busy"}, {7'h0, o_busy}, {7'h0, eb});
    check({tag, " done"}, {7'h0, o_done}, {7'h0, ed});
  endtask

  task automatic drive(logic a, logic [3:0] ach);
    as_a = 1'b0; ach_a = 4'h0; as_b = 1'b0; ach_b = 4'h0; as_c = 1'b0; ach_c = 1'b0;
    case (cur)
      0: begin as_a = a; ach_a = ach; end
      1: begin as_b = a; ach_b = ach; end
      default: begin as_c = a; ach_c = ach[0]; end
    endcase
  endtask

  // Each row repetition: drive inputs, take one edge, sample 1 time unit later.
  task automatic run_vecs(string tag);
    int edge_no = 0;
    foreach (vq[k]) begin
      for (int r = 0; r < vq[k].n; r++) begin
        drive(vq[k].a, vq[k].ach);
        @(posedge clk); #1;
        edge_no++;
        check_all($sformatf("%s e%0d", tag, edge_no), vq[k].exp_out, vq[k].exp_busy, vq[k].exp_done);
      end
    end
    drive(1'b0, 4'h0);
    vq.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    cur = 0;
    drive(1'b0, 4'h0);
    repeat (2) @(posedge clk);
    #1;

    // Reset values of all three configurations
    cur = 0; #1; check_all("rstA", 4'hF, 1'b0, 1'b0);
    cur = 1; #1; check_all("rstB", 4'h0, 1'b1, 1'b0);
    cur = 2; #1; check_all("rstC", 4'hF, 1'b0, 1'b0);

    // Defaults: single ASSERT pulse at edge 10
    cur = 0; rst_a = 1'b1;
    add(9, 0, 4'h0, 4'hF, 0, 0);
    add(1, 1, 4'h0, 4'h0, 1, 0);
    add(3, 0, 4'h0, 4'h0, 1, 0);
    add(2, 0, 4'h0, 4'h1, 1, 0);
    add(2, 0, 4'h0, 4'h3, 1, 0);
    add(2, 0, 4'h0, 4'h7, 1, 0);
    add(1, 0, 4'h0, 4'hF, 0, 1);
    add(2, 0, 4'h0, 4'hF, 0, 0);
    run_vecs("t1");

    // Retrigger at edge 15 after channel 0 released at 14
    add(9, 0, 4'h0, 4'hF, 0, 0);
    add(1, 1, 4'h0, 4'h0, 1, 0);
    add(3, 0, 4'h0, 4'h0, 1, 0);
    add(1, 0, 4'h0, 4'h1, 1, 0);
    add(1, 1, 4'h0, 4'h0, 1, 0);
    add(3, 0, 4'h0, 4'h0, 1, 0);
    add(2, 0, 4'h0, 4'h1, 1, 0);
    add(2, 0, 4'h0, 4'h3, 1, 0);
    add(2, 0, 4'h0, 4'h7, 1, 0);
    add(1, 0, 4'h0, 4'hF, 0, 1);
    add(1, 0, 4'h0, 4'hF, 0, 0);
    run_vecs("t3");

    // ASSERT held over edges 10..12
    add(9, 0, 4'h0, 4'hF, 0, 0);
    add(3, 1, 4'h0, 4'h0, 1, 0);
    add(3, 0, 4'h0, 4'h0, 1, 0);
    add(2, 0, 4'h0, 4'h1, 1, 0);
    add(2, 0, 4'h0, 4'h3, 1, 0);
    add(2, 0, 4'h0, 4'h7, 1, 0);
    add(1, 0, 4'h0, 4'hF, 0, 1);
    add(1, 0, 4'h0, 4'hF, 0, 0);
    run_vecs("t4");

    // Soft assert of channel 2 while idle
    add(4, 0, 4'h0, 4'hF, 0, 0);
    add(3, 0, 4'h4, 4'hB, 0, 0);
    add(2, 0, 4'h0, 4'hF, 0, 0);
    run_vecs("t5");

    // ASSERT with ASSERT_CH[0] on the same edge; override outlives channel 0's release
    add(1, 1, 4'h1, 4'h0, 1, 0);
    add(3, 0, 4'h1, 4'h0, 1, 0);
    add(2, 0, 4'h1, 4'h0, 1, 0);
    add(2, 0, 4'h1, 4'h2, 1, 0);
    add(2, 0, 4'h0, 4'h7, 1, 0);
    add(1, 0, 4'h0, 4'hF, 0, 1);
    add(1, 0, 4'h0, 4'hF, 0, 0);
    run_vecs("tovr");

    // Asynchronous reset mid-release on DUT A
    add(1, 1, 4'h0, 4'h0, 1, 0);
    add(3, 0, 4'h0, 4'h0, 1, 0);
    add(1, 0, 4'h0, 4'h1, 1, 0);
    run_vecs("tmid");
    rst_a = 1'b0; #2;
    check_all("tmid async", 4'hF, 1'b0, 1'b0);
    rst_a = 1'b1;
    add(2, 0, 4'h0, 4'hF, 0, 0);
    run_vecs("tmid after");

    // INIT=0, HOLD=3, STAGGER=1 power-on sequence
    cur = 1; #1;
    check_all("t2 held", 4'h0, 1'b1, 1'b0);
    rst_b = 1'b1;
    add(2, 0, 4'h0, 4'h0, 1, 0);
    add(1, 0, 4'h0, 4'h1, 1, 0);
    add(1, 0, 4'h0, 4'h3, 1, 0);
    add(1, 0, 4'h0, 4'h7, 1, 0);
    add(1, 0, 4'h0, 4'hF, 0, 1);
    add(1, 0, 4'h0, 4'hF, 0, 0);
    run_vecs("t2");

    // Single channel, HOLD=1
    cur = 2; rst_c = 1'b1;
    add(3, 0, 4'h0, 4'hF, 0, 0);
    add(1, 1, 4'h0, 4'hE, 1, 0);
    add(1, 0, 4'h0, 4'hF, 0, 1);
    add(1, 0, 4'h0, 4'hF, 0, 0);
    run_vecs("t6");

    // Single channel: RST pulse while in HOLD
    add(1, 1, 4'h0, 4'hE, 1, 0);
    run_vecs("t6 hold");
    rst_c = 1'b0; #1;
    check_all("t6 async", 4'hF, 1'b0, 1'b0);
    rst_c = 1'b1;
    add(2, 0, 4'h0, 4'hF, 0, 0);
    run_vecs("t6 after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
